// File: rtl/bram_pkg.sv
// bram_pkg: shared definitions for the simple-dual-port BRAM with clear.
//   - READ_FIRST / WRITE_FIRST: values of the RD_MODE collision policy
//   - clr_state_e: clear sequencer state encoding
//   - merge_bytes(): byte-enable merge of a new word into an old word,
//     sized for the widest supported word (callers cast in and out)
package bram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Bytes whose enable is set come from new_word, all others from old_word.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_clear_ctrl.sv
// bram_clear_ctrl: clear sequencer and write-port mux for bram_sdp_clr.
//   clk, rst            : clock, synchronous active-high reset
//   clr_start           : request to zero the whole array (ignored while busy)
//   wr_en/addr/be/data  : user write port
//   clr_busy            : clear sequence in progress
//   wr_drop             : pulse, a user write was discarded during a clear
//   mem_we/addr/be/data : write port actually applied to the array
module bram_clear_ctrl
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_start,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                clr_busy,
  output logic                wr_drop,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_data
);

  // One extra bit so the pointer can reach DEPTH for the terminal compare.
  localparam int               PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(1) << ADDR_W;

  clr_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             clr_busy_q, clr_busy_d;
  logic             wr_drop_q, wr_drop_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_busy_d = clr_busy_q;
    wr_drop_d  = 1'b0;
    ptr_inc    = ptr_q + PTR_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          ptr_d      = '0;
          clr_busy_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        wr_drop_d = wr_en;
        ptr_d     = ptr_inc;
        // Word DEPTH-1 is being zeroed this cycle: leave after this edge.
        if (ptr_inc == DEPTH_CNT) begin
          state_d    = ST_IDLE;
          ptr_d      = '0;
          clr_busy_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The sequencer owns the array write port while clearing; a reset edge
  // writes nothing so an aborted clear leaves the current word untouched.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_be   = wr_be;
    mem_data = wr_data;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = ptr_q[ADDR_W-1:0];
        mem_be   = '1;
        mem_data = '0;
      end else begin
        mem_we = wr_en;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      clr_busy_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_busy_q <= clr_busy_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: rtl/bram_sdp_clr.sv
// bram_sdp_clr: simple-dual-port block RAM with byte enables, selectable
// collision policy, 1- or 2-cycle read latency and a whole-array clear.
//   clk, rst                   : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_be/wr_data: write port (byte enables per 8-bit lane)
//   rd_en/rd_addr              : read request
//   rd_data/rd_valid           : read result after 1 (OUT_REG=0) or 2 cycles
//   clr_start/clr_busy         : start / status of the zeroing sequence
//   wr_drop                    : pulse, a write was discarded during a clear
module bram_sdp_clr
  import bram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                wr_drop
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_data;

  bram_clear_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .clr_busy  (clr_busy),
    .wr_drop   (wr_drop),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_data  (mem_data)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; resetting it would prevent BRAM inference
  // and contents are defined only by writes or the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
  end

  // Collision bypass: the array read yields the pre-write word; WRITE_FIRST
  // substitutes the byte-merged word that the same edge is committing.
  logic [DATA_W-1:0] rd_word, rd_bypass;
  logic              collide;

  always_comb begin
    rd_word   = mem[rd_addr];
    collide   = mem_we && (mem_addr == rd_addr);
    rd_bypass = rd_word;
    if (RD_MODE == WRITE_FIRST && collide) begin
      rd_bypass = DATA_W'(merge_bytes(MAX_DATA_W'(rd_word),
                                      MAX_DATA_W'(mem_data),
                                      MAX_BE_W'(mem_be)));
    end
  end

  // Stage 1: read register; data only loads on an accepted read so the
  // output holds between reads.
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;

  always_comb begin
    s1_valid_d = rd_en;
    s1_data_d  = rd_en ? rd_bypass : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_data_q, s2_data_d;
      logic              s2_valid_q, s2_valid_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign rd_data  = s2_data_q;
      assign rd_valid = s2_valid_q;
    end else begin : g_no_out_reg
      assign rd_data  = s1_data_q;
      assign rd_valid = s1_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_sdp_clr.sv
// tb_bram_sdp_clr: drives two instances with identical stimulus
//   dut0: READ_FIRST, latency 1     dut1: WRITE_FIRST, latency 2
// and compares every cycle against a word-array reference model with a
// queue of expected read results per instance.
module tb_bram_sdp_clr;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clr_start;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          clr_busy0, clr_busy1;
  logic          wr_drop0, wr_drop1;

  bram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .clr_start(clr_start), .clr_busy(clr_busy0),
    .wr_drop(wr_drop0)
  );

  bram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .clr_start(clr_start), .clr_busy(clr_busy1),
    .wr_drop(wr_drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       q0[$];
  rd_exp_t       q1[$];
  logic [DW-1:0] model [DEPTH];
  int            cycle;
  int            checks;
  int            errors;
  bit            m_busy;
  int            m_clr_addr;
  bit            m_drop;
  logic [DW-1:0] last0, last1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_be     = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    clr_start = 1'b0;
  endtask

  // Apply the current inputs for one clock, update the model and compare
  // every output of both instances shortly after the edge.
  task automatic step();
    logic [DW-1:0] old_w, new_w;
    bit            v0, v1;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_busy     = 1'b0;
      m_clr_addr = 0;
      m_drop     = 1'b0;
      last0      = '0;
      last1      = '0;
    end else begin
      if (rd_en) begin
        old_w = model[rd_addr];
        new_w = old_w;
        if (m_busy && m_clr_addr == int'(rd_addr)) new_w = '0;
        else if (!m_busy && wr_en && wr_addr == rd_addr)
          new_w = merge(old_w, wr_data, wr_be);
        q0.push_back('{cycle + 1, old_w});
        q1.push_back('{cycle + 2, new_w});
      end
      m_drop = m_busy && wr_en;
      if (m_busy) begin
        model[m_clr_addr] = '0;
        m_clr_addr++;
        if (m_clr_addr == DEPTH) m_busy = 1'b0;
      end else begin
        if (wr_en) model[wr_addr] = merge(model[wr_addr], wr_data, wr_be);
        if (clr_start) begin
          m_busy     = 1'b1;
          m_clr_addr = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    v0 = (q0.size() > 0) && (q0[0].due == cycle);
    if (v0) begin
      last0 = q0[0].data;
      void'(q0.pop_front());
    end
    v1 = (q1.size() > 0) && (q1[0].due == cycle);
    if (v1) begin
      last1 = q1[0].data;
      void'(q1.pop_front());
    end
    check("rd_valid0", DW'(rd_valid0), DW'(v0));
    check("rd_data0",  rd_data0, last0);
    check("clr_busy0", DW'(clr_busy0), DW'(m_busy));
    check("wr_drop0",  DW'(wr_drop0), DW'(m_drop));
    check("rd_valid1", DW'(rd_valid1), DW'(v1));
    check("rd_data1",  rd_data1, last1);
    check("clr_busy1", DW'(clr_busy1), DW'(m_busy));
    check("wr_drop1",  DW'(wr_drop1), DW'(m_drop));
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be);
    idle();
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    wr_be   = be;
    step();
    idle();
  endtask

  task automatic fill(input logic [DW-1:0] d);
    for (int a = 0; a < DEPTH; a++) write_word(a, d, '1);
  endtask

  initial begin
    int busy_cnt;
    cycle  = 0;
    checks = 0;
    errors = 0;
    idle();

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Basic write then read
    write_word(5, 32'hDEADBEEF, 4'hF);
    rd_en = 1'b1; rd_addr = 5'd5;
    step();
    idle();
    check("basic_valid0", DW'(rd_valid0), DW'(1));
    check("basic_data0", rd_data0, 32'hDEADBEEF);
    step();
    check("basic_data1", rd_data1, 32'hDEADBEEF);

    // Byte enables
    write_word(16, 32'h11223344, 4'hF);
    write_word(16, 32'hAABBCCDD, 4'b0101);
    rd_en = 1'b1; rd_addr = 5'd16;
    step();
    idle();
    check("be_data0", rd_data0, 32'h11BB33DD);
    step();

    // Collision, then a follow-up read of the same word
    write_word(16, 32'h11223344, 4'hF);
    wr_en = 1'b1; wr_addr = 5'd16; wr_data = 32'h55667788; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 5'd16;
    step();
    idle();
    check("coll_rf0", rd_data0, 32'h11223344);
    rd_en = 1'b1; rd_addr = 5'd16;
    step();
    idle();
    check("coll_wf1", rd_data1, 32'h55667788);
    check("after_coll0", rd_data0, 32'h55667788);
    step();
    check("after_coll1", rd_data1, 32'h55667788);

    // Pipelined reads of 0..3 (array holds its own index)
    for (int a = 0; a < DEPTH; a++) write_word(a, DW'(a), '1);
    for (int a = 0; a < 4; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
    end
    idle();
    step();
    step();

    // Randomized traffic with forced collisions and occasional clears
    for (int n = 0; n < 300; n++) begin
      wr_en     = 1'($urandom_range(1));
      wr_addr   = AW'($urandom);
      wr_be     = BW'($urandom);
      wr_data   = $urandom;
      rd_en     = 1'($urandom_range(1));
      rd_addr   = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom);
      clr_start = ($urandom_range(63) == 0);
      step();
    end
    idle();
    for (int n = 0; n < DEPTH + 2; n++) step();

    // Full clear with a dropped write inside the busy window
    fill('1);
    clr_start = 1'b1;
    step();
    idle();
    busy_cnt = clr_busy0 ? 1 : 0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k == 3) begin
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; wr_be = 4'hF;
      end
      step();
      idle();
      if (k == 3) check("drop_pulse", DW'(wr_drop0), DW'(1));
      if (clr_busy0) busy_cnt++;
    end
    check("busy_len", DW'(busy_cnt), DW'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      check("cleared", rd_data0, '0);
    end
    idle();
    step();
    step();

    // Reset after five busy cycles aborts the clear
    fill('1);
    clr_start = 1'b1;
    step();
    idle();
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", DW'(clr_busy0), DW'(0));
    check("abort_valid", DW'(rd_valid0), DW'(0));
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      check("partial", rd_data0, (a < 5) ? '0 : '1);
    end
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
